// File: rtl/serial2parallel_align_pkg.sv
// Shared PHY package: symbol width, K28.5 comma patterns and receive-side types.
package serial2parallel_align_pkg;

  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 4;

  // K28.5 as it appears on the wire, bit 9 received first.
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

endpackage

// File: rtl/serial2parallel_align_comma_detect.sv
// Combinational K28.5 detector; reusable wherever a candidate symbol must be screened.
module comma_detect
  import serial2parallel_align_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA_RDN = K28_5_RDN,
  parameter logic [SYM_W-1:0] COMMA_RDP = K28_5_RDP
) (
  input  logic [SYM_W-1:0] nxt,
  input  logic             fill_ok,
  output logic             match,
  output logic             disparity
);

  logic is_rdn;
  logic is_rdp;

  // Match either disparity; fill_ok blocks matches against reset zeros.
  always_comb begin
    is_rdn    = (nxt == COMMA_RDN);
    is_rdp    = (nxt == COMMA_RDP);
    match     = fill_ok && (is_rdn || is_rdp);
    disparity = fill_ok && is_rdp;
  end

endmodule

// File: rtl/serial2parallel_align.sv
// Receive deserializer: hunts for K28.5, then emits aligned 10-bit symbols.
module serial2parallel_align
  import serial2parallel_align_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA_RDN = K28_5_RDN,
  parameter logic [SYM_W-1:0] COMMA_RDP = K28_5_RDP
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  input  logic             in_1b,
  output logic [SYM_W-1:0] out_10b,
  output logic             out_valid,
  output logic             is_comma,
  output logic             locked,
  output logic             realign
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(SYM_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);

  align_state_e     state_q, state_d;
  logic [SYM_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] out_10b_q, out_10b_d;
  logic             out_valid_q, out_valid_d;
  logic             is_comma_q, is_comma_d;
  logic             locked_q, locked_d;
  logic             realign_q, realign_d;

  logic [SYM_W-1:0] nxt;
  logic             fill_ok;
  logic             match;
  logic             disparity_unused;

  // Candidate word includes the bit arriving now; it needs 9 prior real bits.
  assign nxt     = {sr_q[SYM_W-2:0], in_1b};
  assign fill_ok = (fill_q >= CNT_LAST);

  comma_detect #(
    .COMMA_RDN (COMMA_RDN),
    .COMMA_RDP (COMMA_RDP)
  ) u_comma_detect (
    .nxt       (nxt),
    .fill_ok   (fill_ok),
    .match     (match),
    .disparity (disparity_unused)
  );

  // Next-state and output logic; idle cycles hold everything.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    out_10b_d   = out_10b_q;
    out_valid_d = 1'b0;
    is_comma_d  = 1'b0;
    locked_d    = locked_q;
    realign_d   = 1'b0;

    if (in_valid) begin
      sr_d = nxt;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + CNT_W'(1);
      end

      case (state_q)
        HUNT: begin
          if (match) begin
            out_10b_d   = nxt;
            out_valid_d = 1'b1;
            is_comma_d  = 1'b1;
            locked_d    = 1'b1;
            cnt_d       = '0;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          // A comma anywhere re-anchors the boundary; only off-boundary ones pulse realign.
          if (match || (cnt_q == CNT_LAST)) begin
            out_10b_d   = nxt;
            out_valid_d = 1'b1;
            is_comma_d  = match;
            realign_d   = match && (cnt_q != CNT_LAST);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      out_10b_q   <= '0;
      out_valid_q <= 1'b0;
      is_comma_q  <= 1'b0;
      locked_q    <= 1'b0;
      realign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      out_10b_q   <= out_10b_d;
      out_valid_q <= out_valid_d;
      is_comma_q  <= is_comma_d;
      locked_q    <= locked_d;
      realign_q   <= realign_d;
    end
  end

  assign out_10b   = out_10b_q;
  assign out_valid = out_valid_q;
  assign is_comma  = is_comma_q;
  assign locked    = locked_q;
  assign realign   = realign_q;

endmodule

// File: tb/tb_serial2parallel_align.sv
// Randomized and directed bench for serial2parallel_align against a bit-history model.
module tb_serial2parallel_align;
  import serial2parallel_align_pkg::*;

  logic       clk;
  logic       reset_L;
  logic       in_valid;
  logic       in_1b;
  logic [9:0] out_10b;
  logic       out_valid;
  logic       is_comma;
  logic       locked;
  logic       realign;

  int n_vec;
  int n_err;

  // Model: every valid bit since reset, plus where the last symbol ended.
  bit         hist[$];
  bit         m_locked;
  int         m_bound;
  logic [9:0] m_word;
  bit         m_valid;
  bit         m_comma;
  bit         m_realign;

  serial2parallel_align dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .in_valid  (in_valid),
    .in_1b     (in_1b),
    .out_10b   (out_10b),
    .out_valid (out_valid),
    .is_comma  (is_comma),
    .locked    (locked),
    .realign   (realign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_locked  = 1'b0;
    m_bound   = 0;
    m_word    = '0;
    m_valid   = 1'b0;
    m_comma   = 1'b0;
    m_realign = 1'b0;
  endfunction

  // A symbol is emitted when a comma completes, or 10 bits after the last symbol once locked.
  function automatic void model_step(input bit v, input bit b);
    logic [9:0] w;
    int         n;
    bit         c;
    m_valid   = 1'b0;
    m_comma   = 1'b0;
    m_realign = 1'b0;
    if (!v) return;
    hist.push_back(b);
    n = hist.size();
    if (n < 10) return;
    for (int i = 0; i < 10; i++) w[9-i] = hist[n-10+i];
    c = (w == K28_5_RDN) || (w == K28_5_RDP);
    if (!m_locked) begin
      if (c) begin
        m_locked = 1'b1;
        m_bound  = n;
        m_word   = w;
        m_valid  = 1'b1;
        m_comma  = 1'b1;
      end
    end else if (c || (n - m_bound == 10)) begin
      m_valid   = 1'b1;
      m_comma   = c;
      m_realign = c && (n - m_bound != 10);
      m_word    = w;
      m_bound   = n;
    end
  endfunction

  task automatic cycle(input bit v, input bit b);
    @(negedge clk);
    in_valid = v;
    in_1b    = b;
    model_step(v, b);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("is_comma",  32'(is_comma),  32'(m_comma));
    check("realign",   32'(realign),   32'(m_realign));
    check("locked",    32'(locked),    32'(m_locked));
    check("out_10b",   32'(out_10b),   32'(m_word));
  endtask

  task automatic send_word(input logic [9:0] w, input int gap_pct);
    for (int i = 9; i >= 0; i--) begin
      while ($urandom_range(99) < gap_pct) cycle(1'b0, 1'b0);
      cycle(1'b1, w[i]);
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom_range(1)));
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_10b",   32'(out_10b),   32'd0);
    check("rst_is_comma",  32'(is_comma),  32'd0);
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_realign",   32'(realign),   32'd0);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [9:0] w;
    n_vec    = 0;
    n_err    = 0;
    reset_L  = 1'b1;
    in_valid = 1'b0;
    in_1b    = 1'b0;
    model_reset();

    // RD- comma straight after reset.
    do_reset();
    send_word(10'h0FA, 0);
    check("first_comma_locked", 32'(locked), 32'd1);
    check("first_comma_word",   32'(out_10b), 32'h0FA);

    // False-match guard: 11111010 then 0,1 must not lock.
    do_reset();
    w = 10'b1111101001;
    send_word(w, 0);
    check("guard_unlocked", 32'(locked), 32'd0);
    send_word(10'h305, 0);
    send_word(10'h2AA, 0);

    // Aligned stream after 3 garbage bits, with mid-symbol in_valid gap.
    do_reset();
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    send_word(10'h305, 0);
    send_word(10'h2AA, 0);
    w = 10'h155;
    for (int i = 9; i >= 5; i--) cycle(1'b1, w[i]);
    repeat (4) cycle(1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) cycle(1'b1, w[i]);
    check("gap_word", 32'(out_10b), 32'h155);

    // Off-boundary comma: 3 bits shift, then comma and data on the new boundary.
    send_word(10'h2AA, 0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b1); cycle(1'b1, 1'b0);
    send_word(10'h0FA, 0);
    check("realign_seen", 32'(realign), 32'd1);
    send_word(10'h155, 0);
    check("new_boundary_word", 32'(out_10b), 32'h155);

    // Reset while locked with 5 bits into a symbol.
    send_word(10'h2AA, 0);
    send_bits(5);
    do_reset();
    send_bits(9);
    send_word(10'h305, 0);

    // Randomized streams: garbage, commas, data, slips and gaps.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      send_bits(int'($urandom_range(15)));
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(9) == 0) send_bits(int'($urandom_range(9, 1)));
        if ($urandom_range(9) < 2) w = ($urandom_range(1) != 0) ? K28_5_RDP : K28_5_RDN;
        else w = 10'($urandom_range(1023));
        send_word(w, 15);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial2parallel_align.md
# serial2parallel_align

Receive-side deserializer for the PCIe PHY.
- Samples one serial bit per `clk` cycle, MSb of each 10-bit symbol first, matching the transmit-side serializer.
- Finds symbol boundaries by searching for the K28.5 comma in either running disparity.
- Delivers aligned 10-bit symbols with a one-cycle valid strobe to the 8b10b decoder.

## Interface
- `COMMA_RDN`, default 10'b0011111010: K28.5 pattern, RD−, bit 9 received first.
- `COMMA_RDP`, default 10'b1100000101: K28.5 pattern, RD+.
- `clk`  in  1: single clock; every input is sampled on its rising edge.
- `reset_L`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_1b` carries a bit this cycle. When low, the cycle is ignored: no shift, no count.
- `in_1b`  in  1: serial data bit.
- `out_10b`  out  10: last aligned symbol; bit 9 is the first bit received.
- `out_valid`  out  1: one-cycle pulse, `out_10b` is new.
- `is_comma`  out  1: qualifies `out_valid`; the symbol is a comma.
- `locked`  out  1: symbol alignment established.
- `realign`  out  1: one-cycle pulse; a comma was seen off the current boundary while locked.

## Operation
- **Shift register.** `sr[9:0]`. On a valid bit, `sr <= {sr[8:0], in_1b}`. The candidate word is `nxt = {sr[8:0], in_1b}`.
- **Fill counter.** `fill[3:0]` saturates at 10. No comma match is accepted while the candidate word, including this bit, holds fewer than 10 real bits since reset. This prevents false matches against reset zeros: eight bits 11111010 after reset would otherwise match `COMMA_RDN`.
- **Comma match.** `nxt` equals `COMMA_RDN` or `COMMA_RDP`, and the fill condition is met.
- **FSM, state HUNT (reset state).**
  - Each valid bit shifts the register; no symbols are emitted.
  - On a comma match: `out_10b <= nxt`, `out_valid = 1`, `is_comma = 1`, `locked <= 1`, `cnt <= 0`, go to LOCKED.
- **FSM, state LOCKED.**
  - `cnt[3:0]` counts valid bits 0..9.
  - When a valid bit arrives with `cnt == 9`: emit `nxt` with `out_valid = 1` and `is_comma` = comma match, then `cnt <= 0`.
  - Otherwise `cnt` increments.
- **Off-boundary comma.** A comma match in LOCKED with `cnt != 9`:
  - Emit `nxt` as a comma symbol.
  - `cnt <= 0`, pulse `realign`; `locked` stays 1.
- **No lock-loss timeout.** LOCKED returns to HUNT only on reset.
- **`in_valid` low.** All state is held and `out_valid` is 0. A gap in the middle of a symbol does not break alignment.
- **Outputs are registered.** `out_valid`, `is_comma` and `realign` default to 0 on every cycle they are not asserted.

## Timing
- **Reset values** (asserting `reset_L` low clears these asynchronously): `out_10b = 0`, `out_valid = 0`, `is_comma = 0`, `locked = 0`, `realign = 0`, `sr = 0`, `fill = 0`, `cnt = 0`, state HUNT.
- **Latency.** `out_10b` and `out_valid` appear on the rising edge that samples the 10th bit of the symbol.
- **First comma.** The first comma after reset completes on its 10th valid bit. `locked` rises on that same edge.
- **Steady state.** Symbols come every 10 valid bits, so `out_valid` is high 1 cycle in 10 when `in_valid` is held high.
- **Reset mid-symbol.** Partial bits are discarded; the block re-hunts from an empty register, with `fill = 0`.
- **Simultaneous events.** A comma match on the cycle with `cnt == 9` is a normal aligned comma: no `realign`.

## Structure
- The shared PHY package holds:
  - the K28.5 RD−/RD+ constants (also used by the 8b10b encoder and decoder);
  - the symbol width (10).
- One sub-module is natural: `comma_detect`, purely combinational. Inputs `nxt` and `fill_ok`; outputs `match` and `disparity`. It is reusable by the elastic buffer.
- The FSM, shift register and counters stay in the top module.

## Test plan
- **Reset then RD− comma.** Reset, then shift 0011111010. Expect `out_valid` with `out_10b` = 0x0FA, `is_comma` = 1 and `locked` = 1 on the 10th edge.
- **False-match guard.** Right after reset, shift 11111010 then 0,1. Expect no match on the 8th bit; `locked` stays 0 until a full comma arrives.
- **Aligned stream.** 3 garbage bits, RD+ comma 0x305, then data symbols 0x2AA and 0x155. Expect words 0x305 (comma), 0x2AA, 0x155 at 10-bit spacing.
- **`in_valid` gaps.** Deassert `in_valid` for 4 cycles mid-symbol. Expect the symbol value unchanged and `out_valid` delayed by exactly 4 cycles.
- **Off-boundary comma.** While locked, inject a comma offset by 3 bits. Expect a `realign` pulse, the comma emitted, and subsequent symbols on the new boundary.
- **Reset mid-operation.** Assert `reset_L` low while locked at `cnt` = 5. Expect all outputs 0 immediately (asynchronous) and HUNT behaviour afterward.
